mono_fb_arbiter: RTL and testbench

//  Owns the single-port 512x512x1 SPRAM frame buffer between the dither stage and the Mac CRT timing generator.

---
 rtl/mac_fb_pkg.sv | 20 ++
 rtl/mono_word_fifo.sv | 45 ++++
 rtl/mono_fb_arbiter.sv | 102 ++++++++++
 tb/tb_mono_fb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_fb_pkg.sv
// Shared frame-buffer geometry, FIFO entry layout and address helper
// for the mono 512x512 SPRAM frame buffer.
package mac_fb_pkg;
   localparam int FB_WIDTH     = 512;
   localparam int FB_ROWS      = 512;
   localparam int FB_WORD_BITS = 16;
   localparam int FB_ADDR_BITS = 14;

   typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;

   typedef struct packed {
      fb_addr_t                  addr;
      logic [FB_WORD_BITS-1:0]   bits;
   } fb_entry_t;

   function automatic fb_addr_t fb_addr(input logic [8:0] y,
                                        input logic [8:0] x);
      return {y, x[8:4]};
   endfunction
endpackage

// File: rtl/mono_word_fifo.sv
// Write queue for the frame-buffer arbiter: registered storage,
// wrap-bit pointers, push accepted when full if a pop happens too.
module mono_word_fifo
   import mac_fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  fb_entry_t din,
   output fb_entry_t dout,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   fb_entry_t   r_mem [DEPTH];
   logic        w_pop;
   logic        w_push;

   assign empty  = (r_wptr == r_rptr);
   assign full   = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   assign dout   = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/mono_fb_arbiter.sv
// Frame-buffer SPRAM arbiter: scanout read every 16 pixels, queued writes
// drained in the other slots. Optional MONO_FB_OVERFLOW_CNT_EN drop counter.
module mono_fb_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int FB_X_WORDS = 32,
   parameter int FB_ROWS    = 512
) (
   input  logic        clk_16mhz,
   input  logic        reset,
   input  logic        wr_valid,
   input  logic [11:0] wr_xaddr,
   input  logic [11:0] wr_yaddr,
   input  logic [15:0] wr_bits,
   input  logic [9:0]  scan_xaddr,
   input  logic [8:0]  scan_yaddr,
   output logic [13:0] ram_addr,
   output logic        ram_wen,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   output logic        video_bit,
   output logic        fifo_full
`ifdef MONO_FB_OVERFLOW_CNT_EN
   ,
   output logic [15:0] overflow_cnt
`endif
);
   import mac_fb_pkg::*;

   localparam logic [11:0] X_LIM = 12'(FB_X_WORDS * FB_WORD_BITS);
   localparam logic [11:0] Y_LIM = 12'(FB_ROWS);

   logic        w_read_slot;
   logic        w_pop;
   logic        w_accept;
   logic        w_full;
   logic        w_empty;
   fb_entry_t   w_new;
   fb_entry_t   w_head;
   logic        r_rd_pending;
   logic [15:0] r_shift;

   assign w_read_slot = (scan_xaddr[3:0] == 4'd0);
   assign w_pop       = !w_read_slot && !w_empty;
   assign w_accept    = wr_valid && (wr_xaddr < X_LIM) &&
                        (wr_yaddr < Y_LIM);
   assign w_new.addr  = fb_addr(wr_yaddr[8:0], wr_xaddr[8:0]);
   assign w_new.bits  = wr_bits;

   mono_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_16mhz),
      .reset (reset),
      .push  (w_accept),
      .pop   (w_pop),
      .din   (w_new),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      ram_addr  = fb_addr(scan_yaddr, scan_xaddr[8:0]);
      ram_wen   = 1'b0;
      ram_wdata = w_head.bits;
      if (w_pop) begin
         ram_addr = w_head.addr;
         ram_wen  = 1'b1;
      end
   end

   assign fifo_full = w_full;

   // Read data lands one cycle after the read slot; load it straight out.
   assign video_bit = r_rd_pending ? ram_rdata[15] : r_shift[15];

   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         r_rd_pending <= 1'b0;
         r_shift      <= '0;
      end else begin
         r_rd_pending <= w_read_slot;
         r_shift      <= r_rd_pending ? {ram_rdata[14:0], 1'b0}
                                      : {r_shift[14:0], 1'b0};
      end
   end

`ifdef MONO_FB_OVERFLOW_CNT_EN
   logic [15:0] r_ovf_cnt;
   logic        w_drop;

   assign w_drop       = w_accept && w_full && !w_pop;
   assign overflow_cnt = r_ovf_cnt;

   always_ff @(posedge clk_16mhz) begin
      if (reset)
         r_ovf_cnt <= '0;
      else if (w_drop && (r_ovf_cnt != 16'hFFFF))
         r_ovf_cnt <= r_ovf_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_mono_fb_arbiter.sv
// Self-checking bench for mono_fb_arbiter: vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_mono_fb_arbiter;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic [11:0] wr_xaddr;
   logic [11:0] wr_yaddr;
   logic [15:0] wr_bits;
   logic [9:0]  scan_xaddr;
   logic [8:0]  scan_yaddr;
   logic [13:0] ram_addr;
   logic        ram_wen;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        video_bit;
   logic        fifo_full;
`ifdef MONO_FB_OVERFLOW_CNT_EN
   logic [15:0] overflow_cnt;
`endif

   always #5 clk = ~clk;

   mono_fb_arbiter dut (
      .clk_16mhz  (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_xaddr   (wr_xaddr),
      .wr_yaddr   (wr_yaddr),
      .wr_bits    (wr_bits),
      .scan_xaddr (scan_xaddr),
      .scan_yaddr (scan_yaddr),
      .ram_addr   (ram_addr),
      .ram_wen    (ram_wen),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .video_bit  (video_bit),
      .fifo_full  (fifo_full)
`ifdef MONO_FB_OVERFLOW_CNT_EN
      ,
      .overflow_cnt (overflow_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference model: pending words, drop count, last fetched word
   logic [29:0] mq[$];
   int          mdrop;
   logic        mprev_read;
   logic [15:0] mword;
   int          mk;
   bit          mvalid = 1'b0;

   task automatic step(input logic rst, input logic [9:0] x,
                       input logic [8:0] y, input logic wv,
                       input logic [11:0] wx, input logic [11:0] wy,
                       input logic [15:0] wb, input logic [15:0] rd);
      bit   rslot;
      bit   wr;
      logic ev;
      int   a;
      @(negedge clk);
      reset      = rst;
      scan_xaddr = x;
      scan_yaddr = y;
      wr_valid   = wv;
      wr_xaddr   = wx;
      wr_yaddr   = wy;
      wr_bits    = wb;
      ram_rdata  = rd;
      #1;
      rslot = ((int'(x) % 16) == 0);
      wr    = !rslot && (mq.size() > 0);
      if (mprev_read) begin
         mword = rd;
         mk    = 0;
      end
      ev = (mk < 16) ? mword[15-mk] : 1'b0;
      if (mvalid) begin
         chk("video_bit", 32'(video_bit), 32'(ev));
         chk("ram_wen", 32'(ram_wen), 32'(wr));
         if (wr) begin
            chk("ram_addr_wr", 32'(ram_addr), 32'(mq[0][29:16]));
            chk("ram_wdata", 32'(ram_wdata), 32'(mq[0][15:0]));
         end else begin
            a = int'(y) * 32 + (int'(x) % 512) / 16;
            chk("ram_addr_rd", 32'(ram_addr), 32'(a));
         end
         chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
`ifdef MONO_FB_OVERFLOW_CNT_EN
         chk("overflow_cnt", 32'(overflow_cnt), 32'(mdrop));
`endif
      end
      if (rst) begin
         mq.delete();
         mdrop      = 0;
         mprev_read = 1'b0;
         mword      = '0;
         mk         = 16;
      end else begin
         if (wr) void'(mq.pop_front());
         if (wv && (int'(wx) < 512) && (int'(wy) < 512)) begin
            a = int'(wy) * 32 + int'(wx) / 16;
            if (mq.size() < DEPTH)
               mq.push_back({a[13:0], wb});
            else if (mdrop < 65535)
               mdrop++;
         end
         mprev_read = rslot;
         if (mk < 16) mk++;
      end
   endtask

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      logic        wv;
      logic [11:0] wx;
      logic [11:0] wy;
      logic [15:0] wb;
      logic [15:0] rd;
      logic        cv;
      logic        ev;
      logic        ew;
      logic        cw;
      logic [13:0] ea;
      logic [15:0] ed;
   } vec_t;

   vec_t        tbl[$];
   vec_t        v;
   logic [15:0] pat;
   logic [9:0]  rx;
   logic [8:0]  ry;

   initial begin
      pat = 16'hA5C3;
      for (int i = 0; i <= 32; i++) begin
         v = '{x: 10'(i), y: 9'd0, wv: 1'b0, wx: 12'd0, wy: 12'd0,
               wb: 16'd0, rd: pat, cv: 1'b1, ev: 1'b0, ew: 1'b0,
               cw: 1'b0, ea: 14'd0, ed: 16'd0};
         if (i > 0) v.ev = pat[15 - ((i - 1) % 16)];
         tbl.push_back(v);
      end
      tbl.push_back('{10'd3, 9'd0, 1'b1, 12'd32, 12'd5, 16'h1234, pat,
                      1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 16'd0});
      tbl.push_back('{10'd4, 9'd0, 1'b0, 12'd0, 12'd0, 16'h0, pat,
                      1'b0, 1'b0, 1'b1, 1'b1, 14'h00A2, 16'h1234});
      tbl.push_back('{10'd5, 9'd0, 1'b1, 12'd600, 12'd5, 16'hBEEF, pat,
                      1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 16'd0});
      tbl.push_back('{10'd6, 9'd0, 1'b0, 12'd0, 12'd0, 16'h0, pat,
                      1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 16'd0});
      tbl.push_back('{10'd7, 9'd0, 1'b1, 12'd32, 12'd512, 16'hCAFE, pat,
                      1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 16'd0});
      tbl.push_back('{10'd8, 9'd0, 1'b0, 12'd0, 12'd0, 16'h0, pat,
                      1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 16'd0});

      // Reset, then the table
      step(1'b1, 10'd0, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      mvalid = 1'b1;
      step(1'b1, 10'd0, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      foreach (tbl[i]) begin
         v = tbl[i];
         step(1'b0, v.x, v.y, v.wv, v.wx, v.wy, v.wb, v.rd);
         if (v.cv) chk("tbl_video", 32'(video_bit), 32'(v.ev));
         chk("tbl_wen", 32'(ram_wen), 32'(v.ew));
         if (v.cw) begin
            chk("tbl_addr", 32'(ram_addr), 32'(v.ea));
            chk("tbl_wdata", 32'(ram_wdata), 32'(v.ed));
         end
      end

      // Push during a read slot with empty queue
      step(1'b0, 10'd14, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      step(1'b0, 10'd15, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      step(1'b0, 10'd16, 9'd0, 1'b1, 12'd64, 12'd7, 16'h5A5A, 16'd0);
      chk("rdslot_no_wen", 32'(ram_wen), 32'd0);
      step(1'b0, 10'd17, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      chk("rdslot_next_wen", 32'(ram_wen), 32'd1);
      chk("rdslot_next_addr", 32'(ram_addr), 32'h00E4);

      // Six-word burst while scan holds on a read slot
      step(1'b0, 10'd31, 9'd0, 1'b1, 12'd0, 12'd10, 16'h0001, 16'd0);
      for (int i = 1; i < 6; i++)
         step(1'b0, 10'd32, 9'd0, 1'b1, 12'(16 * i), 12'd10,
              16'(i + 1), 16'd0);
      step(1'b0, 10'd33, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      chk("burst_full", 32'(fifo_full), 32'd1);
`ifdef MONO_FB_OVERFLOW_CNT_EN
      chk("burst_ovf", 32'(overflow_cnt), 32'd2);
`endif
      chk("burst_w1_addr", 32'(ram_addr), 32'h0140);
      chk("burst_w1_data", 32'(ram_wdata), 32'h0001);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 10'(33 + i), 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
         chk("burst_order_addr", 32'(ram_addr), 32'(14'h0140 + i));
         chk("burst_order_data", 32'(ram_wdata), 32'(i + 1));
      end
      step(1'b0, 10'd37, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
      chk("burst_drained", 32'(ram_wen), 32'd0);

      // Reset with three queued words
      for (int i = 0; i < 3; i++)
         step(1'b0, 10'd48, 9'd0, 1'b1, 12'(16 * i), 12'd20,
              16'hF0F0, 16'hFFFF);
      step(1'b1, 10'd48, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'hFFFF);
      step(1'b0, 10'd49, 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'hFFFF);
      chk("rst_wen", 32'(ram_wen), 32'd0);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_video", 32'(video_bit), 32'd0);
`ifdef MONO_FB_OVERFLOW_CNT_EN
      chk("rst_ovf", 32'(overflow_cnt), 32'd0);
`endif
      for (int i = 50; i < 64; i++) begin
         step(1'b0, 10'(i), 9'd0, 1'b0, 12'd0, 12'd0, 16'd0, 16'd0);
         chk("rst_no_write", 32'(ram_wen), 32'd0);
      end

      // Randomized traffic, scan occasionally stalled on read slots
      rx = 10'd64;
      ry = 9'd3;
      for (int n = 0; n < 4000; n++) begin
         step(($urandom_range(0, 799) == 0), rx, ry,
              ($urandom_range(0, 9) < 5),
              12'($urandom_range(0, 700)), 12'($urandom_range(0, 560)),
              16'($urandom), 16'($urandom));
         if (!((rx[3:0] == 4'd0) && ($urandom_range(0, 9) < 3))) begin
            rx = rx + 10'd1;
            if (rx == 10'd0) ry = 9'($urandom);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
